// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU issue/capture sequencer: control codes,
// FSM state encoding, flag bit positions and the per-op flag write mask.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SLL  = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_SRA  = 3'b110;
  localparam logic [2:0] OP_LHB  = 3'b111;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_WB
  } state_t;

  // Arithmetic ops own all three flags, logic/shift ops only Z, LHB none.
  function automatic logic [2:0] flag_mask(input logic [2:0] op);
    logic [2:0] mask;
    mask = 3'b000;
    case (op)
      OP_ADD, OP_SUB: mask = 3'b111;
      OP_LHB:         mask = 3'b000;
      default:        mask[FLAG_Z] = 1'b1;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// Architectural {Z,V,N} flag register; on capture, only the bits enabled by
// the op's flag mask take the ALU's flags, the rest hold.
module alu_flag_reg
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       capture,
  input  logic [2:0] op,
  input  logic [2:0] alu_flags,
  output logic [2:0] flags
);

  logic [2:0] mask;

  assign mask = flag_mask(op);

  for (genvar gi = 0; gi < 3; gi++) begin : g_flag_bit
    always_ff @(posedge clk) begin
      if (rst) begin
        flags[gi] <= 1'b0;
      end else if (capture && mask[gi]) begin
        flags[gi] <= alu_flags[gi];
      end
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Issue/capture sequencer for the 16-bit ALU: IDLE -> ISSUE -> WAIT -> WB.
// Define ALU_SEQ_TIMEOUT_EN to build the WAIT-state watchdog and err_timeout.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [2:0]  issue_op,
  input  logic [15:0] issue_a,
  input  logic [15:0] issue_b,
  input  logic [3:0]  issue_shamt,
  input  logic [7:0]  issue_imm8,
  input  logic [3:0]  issue_rd,
  output logic [15:0] alu_data_one,
  output logic [15:0] alu_data_two,
  output logic [3:0]  alu_shift,
  output logic [7:0]  alu_load_half_imm,
  output logic [2:0]  alu_control,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [3:0]  wb_rd,
  output logic [15:0] wb_data,
  output logic [2:0]  flag_reg,
  output logic        err_timeout
);

  state_t      state;
  logic [2:0]  op_reg;
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic [3:0]  shamt_reg;
  logic [7:0]  imm_reg;
  logic [3:0]  rd_reg;
  logic [15:0] wb_data_reg;
  logic        alu_start_reg;
  logic        wb_valid_reg;
  logic        capture;
  logic        timeout_hit;

  // Operand registers only change on accept, so the ALU inputs and wb_rd
  // stay stable for the whole op and through write-back back-pressure.
  assign alu_control       = op_reg;
  assign alu_data_one      = a_reg;
  assign alu_data_two      = b_reg;
  assign alu_shift         = shamt_reg;
  assign alu_load_half_imm = imm_reg;
  assign alu_start         = alu_start_reg;
  assign wb_valid          = wb_valid_reg;
  assign wb_rd             = rd_reg;
  assign wb_data           = wb_data_reg;
  assign issue_ready       = (state == ST_IDLE) && !rst;

  assign capture = (state == ST_WAIT) && alu_done;

`ifdef ALU_SEQ_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       err_reg;

  // done takes priority: the limit only fires on a cycle without done.
  assign timeout_hit = (state == ST_WAIT) && !alu_done &&
                       (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign err_timeout = err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 8'd0;
      err_reg  <= 1'b0;
    end else begin
      if (state == ST_ISSUE) begin
        wait_cnt <= 8'd0;
      end else if ((state == ST_WAIT) && !alu_done) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (timeout_hit) begin
        err_reg <= 1'b1;
      end
    end
  end
`else
  // Legal TIMEOUT_CYCLES is 2..255, so this is constant 0: WAIT never gives up.
  assign timeout_hit = (TIMEOUT_CYCLES == 0);
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      op_reg        <= 3'd0;
      a_reg         <= 16'd0;
      b_reg         <= 16'd0;
      shamt_reg     <= 4'd0;
      imm_reg       <= 8'd0;
      rd_reg        <= 4'd0;
      wb_data_reg   <= 16'd0;
      alu_start_reg <= 1'b0;
      wb_valid_reg  <= 1'b0;
    end else begin
      alu_start_reg <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue_valid && issue_ready) begin
            op_reg        <= issue_op;
            a_reg         <= issue_a;
            b_reg         <= issue_b;
            shamt_reg     <= issue_shamt;
            imm_reg       <= issue_imm8;
            rd_reg        <= issue_rd;
            alu_start_reg <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (alu_done) begin
            wb_data_reg  <= alu_result;
            wb_valid_reg <= 1'b1;
            state        <= ST_WB;
          end else if (timeout_hit) begin
            state <= ST_IDLE;
          end
        end
        ST_WB: begin
          if (wb_ready) begin
            wb_valid_reg <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  alu_flag_reg u_flag_reg (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .op        (op_reg),
    .alu_flags (alu_flags),
    .flags     (flag_reg)
  );

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: the bench plays the ALU and write-back
// sides by hand and compares every output against hand-computed values.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_op;
  logic [15:0] issue_a;
  logic [15:0] issue_b;
  logic [3:0]  issue_shamt;
  logic [7:0]  issue_imm8;
  logic [3:0]  issue_rd;
  logic [15:0] alu_data_one;
  logic [15:0] alu_data_two;
  logic [3:0]  alu_shift;
  logic [7:0]  alu_load_half_imm;
  logic [2:0]  alu_control;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;
  logic [2:0]  alu_flags;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic [2:0]  flag_reg;
  logic        err_timeout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_op          (issue_op),
    .issue_a           (issue_a),
    .issue_b           (issue_b),
    .issue_shamt       (issue_shamt),
    .issue_imm8        (issue_imm8),
    .issue_rd          (issue_rd),
    .alu_data_one      (alu_data_one),
    .alu_data_two      (alu_data_two),
    .alu_shift         (alu_shift),
    .alu_load_half_imm (alu_load_half_imm),
    .alu_control       (alu_control),
    .alu_start         (alu_start),
    .alu_done          (alu_done),
    .alu_result        (alu_result),
    .alu_flags         (alu_flags),
    .wb_valid          (wb_valid),
    .wb_ready          (wb_ready),
    .wb_rd             (wb_rd),
    .wb_data           (wb_data),
    .flag_reg          (flag_reg),
    .err_timeout       (err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full op; done arrives in WAIT cycle dly, write-back held off for hold cycles.
  task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] rd, input int dly, input logic [15:0] res,
                       input logic [2:0] fl, input logic [2:0] exp_flag, input int hold);
    check("idle_ready", issue_ready, 1);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_a     = a;
    issue_b     = b;
    issue_shamt = a[3:0];
    issue_imm8  = b[7:0];
    issue_rd    = rd;
    tick;
    issue_valid = 1'b0;
    check("issue_start", alu_start, 1);
    check("issue_ready_low", issue_ready, 0);
    check("alu_control", alu_control, op);
    check("alu_data_one", alu_data_one, a);
    check("alu_data_two", alu_data_two, b);
    check("alu_shift", alu_shift, a[3:0]);
    check("alu_imm", alu_load_half_imm, b[7:0]);
    if (dly > 1) begin
      alu_done   = 1'b1;
      alu_result = 16'hDEAD;
      alu_flags  = 3'b111;
    end
    tick;
    alu_done   = 1'b0;
    alu_result = 16'h0000;
    alu_flags  = 3'b000;
    check("wait_start_low", alu_start, 0);
    check("wait_no_wb", wb_valid, 0);
    repeat (dly - 1) tick;
    alu_done   = 1'b1;
    alu_result = res;
    alu_flags  = fl;
    tick;
    alu_done   = 1'b0;
    alu_result = 16'h0000;
    alu_flags  = 3'b000;
    check("wb_valid", wb_valid, 1);
    check("wb_rd", wb_rd, rd);
    check("wb_data", wb_data, res);
    check("flag_reg", flag_reg, exp_flag);
    check("wb_issue_ready", issue_ready, 0);
    for (int i = 0; i < hold; i++) begin
      issue_valid = 1'b1;
      issue_op    = ~op;
      issue_a     = 16'h1234;
      tick;
      check("hold_wb_valid", wb_valid, 1);
      check("hold_wb_rd", wb_rd, rd);
      check("hold_wb_data", wb_data, res);
      check("hold_ready", issue_ready, 0);
      check("hold_start", alu_start, 0);
    end
    issue_valid = 1'b0;
    wb_ready    = 1'b1;
    tick;
    wb_ready = 1'b0;
    check("post_wb_valid", wb_valid, 0);
    check("post_ready", issue_ready, 1);
    check("post_start", alu_start, 0);
    check("post_control", alu_control, op);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    issue_valid = 1'b0;
    issue_op    = 3'd0;
    issue_a     = 16'd0;
    issue_b     = 16'd0;
    issue_shamt = 4'd0;
    issue_imm8  = 8'd0;
    issue_rd    = 4'd0;
    alu_done    = 1'b0;
    alu_result  = 16'd0;
    alu_flags   = 3'd0;
    wb_ready    = 1'b0;
    tick;
    tick;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_start", alu_start, 0);
    check("rst_flag", flag_reg, 0);
    check("rst_err", err_timeout, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_alu_a", alu_data_one, 0);
    check("rst_alu_ctl", alu_control, 0);
    rst = 1'b0;
    tick;
    check("rst_release_ready", issue_ready, 1);

    //    op       a         b         rd  dly res       fl      flag    hold
    do_op(3'b000, 16'h7FFF, 16'h0001, 4'd3, 1, 16'h8000, 3'b011, 3'b011, 0); // ADD
    do_op(3'b011, 16'h00FF, 16'h00FF, 4'd4, 2, 16'h0000, 3'b100, 3'b111, 0); // XOR
    do_op(3'b001, 16'h0009, 16'h0004, 4'd1, 1, 16'h0005, 3'b000, 3'b000, 0); // SUB
    do_op(3'b111, 16'h00AB, 16'h0034, 4'd7, 1, 16'h34AB, 3'b111, 3'b000, 0); // LHB
    do_op(3'b010, 16'hF0F0, 16'h0F0F, 4'd8, 2, 16'hFFFF, 3'b011, 3'b000, 0); // NAND
    do_op(3'b100, 16'h0000, 16'h0000, 4'd9, 3, 16'h0000, 3'b111, 3'b100, 5); // SLL

`ifdef ALU_SEQ_TIMEOUT_EN
    do_op(3'b000, 16'h0001, 16'h0002, 4'd2, 16, 16'h0003, 3'b101, 3'b101, 0);
    check("late_done_err", err_timeout, 0);
    issue_valid = 1'b1;
    issue_op    = 3'b000;
    issue_rd    = 4'd5;
    tick;
    issue_valid = 1'b0;
    tick;
    repeat (15) tick;
    check("to_last_wait_err", err_timeout, 0);
    check("to_last_wait_ready", issue_ready, 0);
    tick;
    check("to_err", err_timeout, 1);
    check("to_ready", issue_ready, 1);
    check("to_no_wb", wb_valid, 0);
    check("to_flag_kept", flag_reg, 3'b101);
    repeat (2) tick;
    check("to_still_no_wb", wb_valid, 0);
    check("to_err_sticky", err_timeout, 1);
`else
    do_op(3'b101, 16'h0040, 16'h0000, 4'd6, 20, 16'h0040, 3'b011, 3'b000, 0); // SRL
    check("long_wait_err", err_timeout, 0);
`endif

    issue_valid = 1'b1;
    issue_op    = 3'b000;
    issue_rd    = 4'd11;
    tick;
    issue_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    check("midrst_flag", flag_reg, 0);
    check("midrst_err", err_timeout, 0);
    check("midrst_wb_valid", wb_valid, 0);
    check("midrst_wb_data", wb_data, 0);
    rst        = 1'b0;
    alu_done   = 1'b1;
    alu_result = 16'hFFFF;
    alu_flags  = 3'b111;
    repeat (3) tick;
    check("midrst_no_wb", wb_valid, 0);
    check("midrst_ready", issue_ready, 1);
    check("midrst_flag_held", flag_reg, 0);
    alu_done = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
